store_rmw_sequencer: RTL and testbench

- Multicycle FSM that runs every store instruction (sw/sh/sb) against the byte-addressed data memory.
- For sh/sb it first performs a read so the MDR holds the current memory word, then drives the store-merge select and memory write enable.
- For sw it writes directly.
- Sits between the main control unit and the memory/MDR/store-merge datapath, and owns the SS_control select.

---
 rtl/store_rmw_sequencer_pkg.sv | 30 +++
 rtl/store_rmw_sequencer.sv | 102 ++++++++++
 tb/tb_store_rmw_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_rmw_sequencer_pkg.sv
// Shared encodings for the store read-modify-write sequencer: store types,
// store-merge selects, FSM states and the alignment check.
package store_rmw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_BAD = 2'b11
    } store_type_t;

    // Store-merge selects share the store type encoding so the latched type drives them directly.
    localparam logic [1:0] SS_WORD = 2'b00;
    localparam logic [1:0] SS_HALF = 2'b01;
    localparam logic [1:0] SS_BYTE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_ERR
    } state_t;

    function automatic logic misaligned(input logic [1:0] ty, input logic [1:0] addr_lo);
        return ((ty == ST_SW) && (addr_lo != 2'b00)) ||
               ((ty == ST_SH) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/store_rmw_sequencer.sv
// Multicycle store sequencer: sw writes directly, sh/sb read the current word
// into the MDR first, then write through the store-merge stage.
module store_rmw_sequencer
    import store_rmw_sequencer_pkg::*;
#(
    parameter int unsigned READ_LAT    = 1,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr_in,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        mdr_load,
    output logic [1:0]  SS_control,
    output logic        busy,
    output logic        done,
    output logic        store_err
);

    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    ty_q;

    // Outputs are registered alongside the next state so they are valid for the whole state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ty_q       <= '0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mdr_load   <= 1'b0;
            SS_control <= SS_WORD;
            busy       <= 1'b0;
            done       <= 1'b0;
            store_err  <= 1'b0;
        end else begin
            mem_wr    <= 1'b0;
            mdr_load  <= 1'b0;
            done      <= 1'b0;
            store_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ty_q <= store_type;
                        busy <= 1'b1;
                        if ((store_type == ST_BAD) ||
                            (CHECK_ALIGN && misaligned(store_type, addr_in[1:0]))) begin
                            state      <= S_ERR;
                            store_err  <= 1'b1;
                            SS_control <= SS_WORD;
                        end else if (store_type == ST_SW) begin
                            state      <= S_WRITE;
                            mem_wr     <= 1'b1;
                            mem_addr   <= addr_in;
                            SS_control <= store_type;
                        end else begin
                            state      <= S_READ;
                            mem_addr   <= addr_in;
                            cnt        <= CW'(READ_LAT - 1);
                            SS_control <= SS_WORD;
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        state      <= S_CAPTURE;
                        mdr_load   <= 1'b1;
                        SS_control <= ty_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    state  <= S_WRITE;
                    mem_wr <= 1'b1;
                end
                S_WRITE: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    SS_control <= SS_WORD;
                end
                S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    SS_control <= SS_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: three instances (READ_LAT 1/2/3, alignment check on/off/on)
// share stimulus; a transaction-timeline model checks every cycle, directed literals pin it.
module tb_store_rmw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  store_type = 2'b00;
    logic [31:0] addr_in = '0;

    logic [31:0] mem_addr_o [3];
    logic        mem_wr_o   [3];
    logic        mdr_o      [3];
    logic [1:0]  ss_o       [3];
    logic        busy_o     [3];
    logic        done_o     [3];
    logic        err_o      [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        store_rmw_sequencer #(
            .READ_LAT   (g + 1),
            .CHECK_ALIGN(g != 1)
        ) dut (
            .clk       (clk),
            .reset     (rst),
            .start     (start),
            .store_type(store_type),
            .addr_in   (addr_in),
            .mem_addr  (mem_addr_o[g]),
            .mem_wr    (mem_wr_o[g]),
            .mdr_load  (mdr_o[g]),
            .SS_control(ss_o[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .store_err (err_o[g])
        );
    end

    // Model: each accepted store is a timeline of phases measured from its start cycle.
    typedef struct {
        bit          valid;
        int          t;
        int          kind;   // 0 direct write, 1 read-modify-write, 2 rejected
        logic [1:0]  ty;
        logic [31:0] addr;
    } txn_t;

    txn_t        cur [3];
    txn_t        prv [3];
    logic [31:0] maddr [3];
    int          mcyc = 0;

    // bits: {busy, mem_wr, mdr_load, done, store_err, SS_control[1:0]}
    function automatic logic [6:0] phase(input txn_t x, input int c, input int lat);
        int o;
        logic [6:0] r;
        r = '0;
        o = c - x.t;
        if (!x.valid || o < 1) return r;
        case (x.kind)
            0: begin
                if (o == 1)      r = {5'b11000, x.ty};
                else if (o == 2) r[3] = 1'b1;
            end
            1: begin
                if (o <= lat)          r[6] = 1'b1;
                else if (o == lat + 1) r = {5'b10100, x.ty};
                else if (o == lat + 2) r = {5'b11000, x.ty};
                else if (o == lat + 3) r[3] = 1'b1;
            end
            default: if (o == 1) r = 7'b1000100;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        logic [6:0]  e;
        logic [38:0] ev, av;
        bit          bad;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cur[i].valid = 1'b0;
                prv[i].valid = 1'b0;
                maddr[i] = '0;
                e = '0;
            end else begin
                e = phase(prv[i], mcyc, i + 1) | phase(cur[i], mcyc, i + 1);
                if (cur[i].valid && cur[i].kind != 2 && mcyc > cur[i].t) maddr[i] = cur[i].addr;
            end
            ev = {e, maddr[i]};
            av = {busy_o[i], mem_wr_o[i], mdr_o[i], done_o[i], err_o[i], ss_o[i], mem_addr_o[i]};
            checks++;
            if (av !== ev) begin
                failures++;
                $display("FAIL model_dut%0d cyc=%0d actual={busy,wr,mdr,done,err,ss}=%b addr=%h required=%b addr=%h",
                         i, mcyc, av[38:32], av[31:0], ev[38:32], ev[31:0]);
            end
            if (!rst && start && !e[6]) begin
                bad = (store_type == 2'b11) ||
                      ((i != 1) && (((store_type == 2'b00) && (addr_in[1:0] != 2'b00)) ||
                                    ((store_type == 2'b01) && addr_in[0])));
                prv[i] = cur[i];
                cur[i].valid = 1'b1;
                cur[i].t     = mcyc;
                cur[i].kind  = bad ? 2 : ((store_type == 2'b00) ? 0 : 1);
                cur[i].ty    = store_type;
                cur[i].addr  = addr_in;
            end
        end
        mcyc++;
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [1:0] ty, input logic [31:0] a);
        @(posedge clk);
        #1;
        start = s;
        store_type = ty;
        addr_in = a;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 32'h0);
    endtask

    int wrcnt;

    initial begin
        idle(2);
        @(negedge clk);
        lit("reset_busy", {31'b0, busy_o[0]}, 32'd0);
        lit("reset_addr", mem_addr_o[2], 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // sw at 0x100
        cyc(1'b1, 2'b00, 32'h100);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sw_wr", {31'b0, mem_wr_o[0]}, 32'd1);
        lit("sw_addr", mem_addr_o[0], 32'h100);
        lit("sw_ss", {30'b0, ss_o[0]}, 32'd0);
        lit("sw_mdr", {31'b0, mdr_o[0]}, 32'd0);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sw_done", {31'b0, done_o[0]}, 32'd1);
        idle(2);

        // sb at 0x103 on READ_LAT=2
        cyc(1'b1, 2'b10, 32'h103);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sb_read_busy", {31'b0, busy_o[1]}, 32'd1);
        lit("sb_read_wr", {31'b0, mem_wr_o[1]}, 32'd0);
        cyc(1'b0, 2'b00, 32'h0);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sb_mdr", {31'b0, mdr_o[1]}, 32'd1);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sb_wr", {31'b0, mem_wr_o[1]}, 32'd1);
        lit("sb_ss", {30'b0, ss_o[1]}, 32'd2);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sb_done", {31'b0, done_o[1]}, 32'd1);
        idle(3);

        // misaligned sh at 0x101: rejected with check, normal without
        cyc(1'b1, 2'b01, 32'h101);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sh_err", {31'b0, err_o[0]}, 32'd1);
        lit("sh_err_wr", {31'b0, mem_wr_o[0]}, 32'd0);
        idle(3);
        @(negedge clk);
        lit("sh_noalign_wr", {31'b0, mem_wr_o[1]}, 32'd1);
        lit("sh_noalign_ss", {30'b0, ss_o[1]}, 32'd1);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("sh_noalign_done", {31'b0, done_o[1]}, 32'd1);
        lit("sh_err_nodone", {31'b0, done_o[0]}, 32'd0);
        idle(2);

        // illegal type, then sw during the error cycle is ignored
        cyc(1'b1, 2'b11, 32'h200);
        cyc(1'b1, 2'b00, 32'h300);
        @(negedge clk);
        lit("ill_err", {31'b0, err_o[0]}, 32'd1);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("ill_busy", {31'b0, busy_o[0]}, 32'd0);
        lit("ill_wr", {31'b0, mem_wr_o[0]}, 32'd0);
        idle(2);

        // start held during sb; sw in the done cycle on READ_LAT=1
        wrcnt = 0;
        cyc(1'b1, 2'b10, 32'h400);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 2'b10, 32'h500);
            @(negedge clk);
            wrcnt += int'(mem_wr_o[0]);
        end
        cyc(1'b1, 2'b00, 32'h600);
        @(negedge clk);
        wrcnt += int'(mem_wr_o[0]);
        lit("hold_done", {31'b0, done_o[0]}, 32'd1);
        lit("hold_one_write", wrcnt, 32'd1);
        cyc(1'b0, 2'b00, 32'h0);
        @(negedge clk);
        lit("back2back_wr", {31'b0, mem_wr_o[0]}, 32'd1);
        lit("back2back_addr", mem_addr_o[0], 32'h600);
        idle(4);

        // reset in the middle of READ on READ_LAT=3
        cyc(1'b1, 2'b10, 32'h700);
        cyc(1'b0, 2'b00, 32'h0);
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        @(negedge clk);
        lit("rst_busy", {31'b0, busy_o[2]}, 32'd0);
        lit("rst_addr", mem_addr_o[2], 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        wrcnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 2'b00, 32'h0);
            @(negedge clk);
            wrcnt += int'(mem_wr_o[2]);
        end
        lit("rst_no_write", wrcnt, 32'd0);
        lit("rst_idle", {31'b0, busy_o[2]}, 32'd0);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
